// File: rtl/ext_ref_clk_monitor_pkg.sv
// Shared types and helpers for the external reference clock monitor.
package ext_ref_clk_monitor_pkg;

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } state_e;

  localparam int unsigned GOOD_CNT_W = 4;

  typedef struct packed {
    int unsigned lo;
    int unsigned hi;
  } window_t;

  // Inclusive window of acceptable periods; the low bound clamps at zero.
  function automatic window_t period_window(input int unsigned nom, input int unsigned tol);
    window_t w;
    w.lo = (tol >= nom) ? 0 : nom - tol;
    w.hi = nom + tol;
    return w;
  endfunction

endpackage

// File: rtl/ext_ref_clk_monitor_sync_edge_det.sv
// Multi-flop synchronizer for an asynchronous strobe plus a rising-edge pulse.
module ext_ref_clk_monitor_sync_edge_det #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_async,
  output logic o_rise
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_dly;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync <= '0;
      r_dly  <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
      r_dly  <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_rise = r_sync[SYNC_STAGES-1] & ~r_dly;

endmodule

// File: rtl/ext_ref_clk_monitor.sv
// Qualifies an external reference clock in the system clock domain by
// measuring its period and tracking SEARCH / ACQUIRE / LOCKED status.
module ext_ref_clk_monitor
  import ext_ref_clk_monitor_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned NOM_PERIOD  = 12,
  parameter int unsigned TOL         = 1,
  parameter int unsigned LOCK_COUNT  = 8,
  parameter int unsigned TIMEOUT     = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ref_in,
  output logic                  ref_edge,
  output logic [CNT_W-1:0]      period,
  output logic                  period_vld,
  output logic                  locked,
  output logic                  lost,
  output logic [GOOD_CNT_W-1:0] good_cnt
);

  localparam window_t                WIN       = period_window(NOM_PERIOD, TOL);
  localparam logic [CNT_W-1:0]       WIN_LO    = CNT_W'(WIN.lo);
  localparam logic [CNT_W-1:0]       WIN_HI    = CNT_W'(WIN.hi);
  localparam logic [CNT_W-1:0]       TIMEOUT_V = CNT_W'(TIMEOUT);
  localparam logic [GOOD_CNT_W-1:0]  LOCK_V    = GOOD_CNT_W'(LOCK_COUNT);

  logic                  w_edge;
  logic                  w_good;
  logic                  w_timeout;
  logic                  w_vld;
  logic [GOOD_CNT_W-1:0] w_good_inc;

  logic [CNT_W-1:0]      r_cnt;
  logic [CNT_W-1:0]      r_period;
  logic [GOOD_CNT_W-1:0] r_good;
  logic                  r_locked;
  logic                  r_lost;
  state_e                r_state;

  ext_ref_clk_monitor_sync_edge_det #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_async(ref_in),
    .o_rise (w_edge)
  );

  assign w_good     = (r_cnt >= WIN_LO) && (r_cnt <= WIN_HI);
  assign w_timeout  = !w_edge && (r_cnt == TIMEOUT_V);
  assign w_vld      = w_edge && (r_state != SEARCH);
  assign w_good_inc = (r_good == '1) ? r_good : r_good + GOOD_CNT_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (w_edge) begin
      r_cnt <= CNT_W'(1);
    end else if (r_cnt != '1) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= SEARCH;
      r_good   <= '0;
      r_locked <= 1'b0;
      r_lost   <= 1'b0;
      r_period <= '0;
    end else begin
      r_lost <= 1'b0;
      if (w_vld) begin
        r_period <= r_cnt;
      end
      case (r_state)
        SEARCH: begin
          if (w_edge) begin
            r_state <= ACQUIRE;
            r_good  <= '0;
          end
        end
        ACQUIRE: begin
          if (w_edge) begin
            if (w_good) begin
              r_good <= w_good_inc;
              if (w_good_inc == LOCK_V) begin
                r_state  <= LOCKED;
                r_locked <= 1'b1;
              end
            end else begin
              r_good <= '0;
            end
          end else if (w_timeout) begin
            r_state <= SEARCH;
            r_good  <= '0;
          end
        end
        LOCKED: begin
          if (w_edge) begin
            if (w_good) begin
              r_good <= w_good_inc;
            end else begin
              r_state  <= ACQUIRE;
              r_good   <= '0;
              r_locked <= 1'b0;
              r_lost   <= 1'b1;
            end
          end else if (w_timeout) begin
            r_state  <= SEARCH;
            r_good   <= '0;
            r_locked <= 1'b0;
            r_lost   <= 1'b1;
          end
        end
        default: begin
          r_state  <= SEARCH;
          r_good   <= '0;
          r_locked <= 1'b0;
        end
      endcase
    end
  end

  // The freshly measured value is presented alongside period_vld, then held.
  assign ref_edge   = w_edge;
  assign period_vld = w_vld;
  assign period     = w_vld ? r_cnt : r_period;
  assign locked     = r_locked;
  assign lost       = r_lost;
  assign good_cnt   = r_good;

endmodule
